// File: rtl/eth_reg_arbiter.sv
// ---------------------------------------------------------------------------
// eth_reg_arbiter
// Two-requester round-robin arbiter in front of the Ethernet controller
// register port. Requester 0 is the host MMIO path, requester 1 the
// descriptor/DMA sequencer. Every accepted access yields exactly one
// response (read data, or zero for a write). A requester may hold the grant
// across several accesses with its lock input.
//
// Ports
//   clk_i, reset_i         clock, asynchronous active-high reset
//   rN_v_i / rN_ready_o    request handshake (ready-and), N in {0,1}
//   rN_w_i, rN_addr_i,     request: write flag, address, byte mask,
//   rN_mask_i, rN_data_i   write data
//   rN_lock_i              keep the grant after this access
//   rN_resp_v_o,           response valid / data (0 for writes)
//   rN_resp_data_o
//   rN_resp_ready_i        response consumed
//   addr_o, write_en_o,    controller register port
//   read_en_o, write_mask_o,
//   write_data_o
//   read_data_i            controller read data, valid cycle after read_en_o
// ---------------------------------------------------------------------------
module eth_reg_arbiter #(
    parameter int data_width_p = 64,
    parameter int addr_width_p = 14
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      r0_v_i,
    output logic                      r0_ready_o,
    input  logic                      r0_w_i,
    input  logic [addr_width_p-1:0]   r0_addr_i,
    input  logic [data_width_p/8-1:0] r0_mask_i,
    input  logic [data_width_p-1:0]   r0_data_i,
    input  logic                      r0_lock_i,
    output logic                      r0_resp_v_o,
    output logic [data_width_p-1:0]   r0_resp_data_o,
    input  logic                      r0_resp_ready_i,
    input  logic                      r1_v_i,
    output logic                      r1_ready_o,
    input  logic                      r1_w_i,
    input  logic [addr_width_p-1:0]   r1_addr_i,
    input  logic [data_width_p/8-1:0] r1_mask_i,
    input  logic [data_width_p-1:0]   r1_data_i,
    input  logic                      r1_lock_i,
    output logic                      r1_resp_v_o,
    output logic [data_width_p-1:0]   r1_resp_data_o,
    input  logic                      r1_resp_ready_i,
    output logic [addr_width_p-1:0]   addr_o,
    output logic                      write_en_o,
    output logic                      read_en_o,
    output logic [data_width_p/8-1:0] write_mask_o,
    output logic [data_width_p-1:0]   write_data_o,
    input  logic [data_width_p-1:0]   read_data_i
);
    localparam int mask_width_lp = data_width_p / 8;

    // Indexable views of the two requester ports
    logic [1:0]               v_s, w_s, lock_s, resp_ready_s;
    logic [addr_width_p-1:0]  addr_s [2];
    logic [mask_width_lp-1:0] mask_s [2];
    logic [data_width_p-1:0]  data_s [2];

    // State: access issued last cycle, its kind, skid buffer, lock, pointer
    logic [1:0]               inflight_q, inflight_d;
    logic [1:0]               inflight_w_q, inflight_w_d;
    logic [1:0]               buf_v_q, buf_v_d;
    logic [data_width_p-1:0]  buf_data_q [2];
    logic [data_width_p-1:0]  buf_data_d [2];
    logic                     lock_v_q, lock_v_d;
    logic                     lock_id_q, lock_id_d;
    logic                     last_q, last_d;   // requester granted most recently

    logic [1:0]               elig_s, resp_v_s;
    logic [data_width_p-1:0]  resp_data_s [2];
    logic                     gnt_v_s, gnt_id_s;

    // Gather requester ports into arrays
    always_comb begin
        v_s          = {r1_v_i, r0_v_i};
        w_s          = {r1_w_i, r0_w_i};
        lock_s       = {r1_lock_i, r0_lock_i};
        resp_ready_s = {r1_resp_ready_i, r0_resp_ready_i};
        addr_s[0]    = r0_addr_i;
        addr_s[1]    = r1_addr_i;
        mask_s[0]    = r0_mask_i;
        mask_s[1]    = r1_mask_i;
        data_s[0]    = r0_data_i;
        data_s[1]    = r1_data_i;
    end

    // Response selection and eligibility per requester
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            resp_v_s[n] = inflight_q[n] | buf_v_q[n];
            // A buffered response always wins; read data is taken live only
            // in the cycle right after the read enable.
            if (buf_v_q[n]) begin
                resp_data_s[n] = buf_data_q[n];
            end else if (inflight_q[n] & ~inflight_w_q[n]) begin
                resp_data_s[n] = read_data_i;
            end else begin
                resp_data_s[n] = '0;
            end
            // A new grant is safe only if its response cannot collide with
            // an unconsumed one.
            elig_s[n] = v_s[n] & ~buf_v_q[n] & (~inflight_q[n] | resp_ready_s[n]);
        end
    end

    // Grant selection: lock owner only, else round-robin
    always_comb begin
        gnt_v_s  = 1'b0;
        gnt_id_s = 1'b0;
        if (reset_i) begin
            gnt_v_s  = 1'b0;
            gnt_id_s = 1'b0;
        end else if (lock_v_q) begin
            gnt_v_s  = elig_s[lock_id_q];
            gnt_id_s = lock_id_q;
        end else if (elig_s == 2'b11) begin
            gnt_v_s  = 1'b1;
            gnt_id_s = ~last_q;
        end else if (elig_s[0]) begin
            gnt_v_s  = 1'b1;
            gnt_id_s = 1'b0;
        end else if (elig_s[1]) begin
            gnt_v_s  = 1'b1;
            gnt_id_s = 1'b1;
        end else begin
            gnt_v_s  = 1'b0;
            gnt_id_s = 1'b0;
        end
    end

    // Controller port drive and requester-facing outputs
    always_comb begin
        if (gnt_v_s) begin
            addr_o       = addr_s[gnt_id_s];
            write_en_o   = w_s[gnt_id_s];
            read_en_o    = ~w_s[gnt_id_s];
            write_mask_o = w_s[gnt_id_s] ? mask_s[gnt_id_s] : '0;
            write_data_o = data_s[gnt_id_s];
        end else begin
            addr_o       = '0;
            write_en_o   = 1'b0;
            read_en_o    = 1'b0;
            write_mask_o = '0;
            write_data_o = '0;
        end
        r0_ready_o     = gnt_v_s & ~gnt_id_s;
        r1_ready_o     = gnt_v_s & gnt_id_s;
        r0_resp_v_o    = resp_v_s[0];
        r1_resp_v_o    = resp_v_s[1];
        r0_resp_data_o = resp_data_s[0];
        r1_resp_data_o = resp_data_s[1];
    end

    // Next-state computation
    always_comb begin
        lock_v_d  = lock_v_q;
        lock_id_d = lock_id_q;
        last_d    = last_q;
        if (gnt_v_s) begin
            lock_v_d  = lock_s[gnt_id_s];
            lock_id_d = gnt_id_s;
            last_d    = gnt_id_s;
        end else begin
            lock_v_d  = lock_v_q;
            lock_id_d = lock_id_q;
            last_d    = last_q;
        end
        for (int n = 0; n < 2; n++) begin
            inflight_d[n]   = gnt_v_s & (gnt_id_s == 1'(n));
            inflight_w_d[n] = (gnt_v_s & (gnt_id_s == 1'(n))) ? w_s[n] : inflight_w_q[n];
            buf_data_d[n]   = buf_data_q[n];
            if (buf_v_q[n]) begin
                buf_v_d[n] = ~resp_ready_s[n];
            end else if (inflight_q[n] & ~resp_ready_s[n]) begin
                buf_v_d[n]    = 1'b1;
                buf_data_d[n] = resp_data_s[n];
            end else begin
                buf_v_d[n] = 1'b0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            inflight_q   <= 2'b00;
            inflight_w_q <= 2'b00;
            buf_v_q      <= 2'b00;
            lock_v_q     <= 1'b0;
            lock_id_q    <= 1'b0;
            last_q       <= 1'b1;
            for (int n = 0; n < 2; n++) begin
                buf_data_q[n] <= '0;
            end
        end else begin
            inflight_q   <= inflight_d;
            inflight_w_q <= inflight_w_d;
            buf_v_q      <= buf_v_d;
            lock_v_q     <= lock_v_d;
            lock_id_q    <= lock_id_d;
            last_q       <= last_d;
            for (int n = 0; n < 2; n++) begin
                buf_data_q[n] <= buf_data_d[n];
            end
        end
    end

endmodule
